// File: rtl/cw_trace_reader.sv
// ChipWatcher trace readout: walks the capture RAM from the oldest sample to
// the newest and streams each word LSB-first on jtdo while the host shifts.
// The next word is fetched during the tail of the current one, so shifting
// across word boundaries needs no idle cycles.
module cw_trace_reader #(
  parameter int DATA_WIDTH = 91,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 1024
) (
  input  logic                  jtck,
  input  logic                  jrstn,
  input  logic                  jscan_sel,
  input  logic                  jshift,
  input  logic                  jupdate,
  output logic                  jtdo,
  input  logic                  cap_done,
  input  logic [ADDR_WIDTH-1:0] trig_ptr,
  output logic                  rd_ce,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0]         BIT_LAST = CW'(DATA_WIDTH - 1);
  // Prefetch two bits early: RAM data lands one cycle after rd_ce and is
  // then consumed on the last-bit edge.
  localparam logic [CW-1:0]         BIT_PRE  = CW'(DATA_WIDTH - 3);
  localparam logic [ADDR_WIDTH-1:0] PTR_MAX  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   WL_FULL  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   WL_ONE   = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHIFT, DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH:0]   words_left;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] sr;

  logic start, last_bit, more_words;

  // Explicit wrap compare so DEPTH need not be a power of two.
  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  assign start      = jupdate & jscan_sel & cap_done;
  assign last_bit   = (bit_cnt == BIT_LAST);
  assign more_words = (words_left > WL_ONE);

  assign rd_addr = ptr;
  assign rd_ce   = (state == FETCH) |
                   ((state == SHIFT) & jshift & (bit_cnt == BIT_PRE) & more_words);
  assign jtdo    = (state == SHIFT) & jscan_sel & sr[0];

  // Readout FSM: restart beats abort, abort beats normal sequencing.
  always_ff @(posedge jtck or negedge jrstn) begin
    if (!jrstn) begin
      state      <= IDLE;
      ptr        <= '0;
      words_left <= '0;
      bit_cnt    <= '0;
      sr         <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (start) begin
      ptr        <= ptr_inc(trig_ptr);
      words_left <= WL_FULL;
      state      <= FETCH;
      busy       <= 1'b1;
      done       <= 1'b0;
    end else if (!jscan_sel && state != IDLE) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        FETCH: state <= LOAD;
        LOAD: begin
          sr      <= rd_data;
          bit_cnt <= '0;
          ptr     <= ptr_inc(ptr);
          state   <= SHIFT;
        end
        SHIFT: begin
          if (jshift) begin
            if (last_bit) begin
              words_left <= words_left - 1'b1;
              if (more_words) begin
                // prefetched word is already on rd_data
                sr      <= rd_data;
                bit_cnt <= '0;
                ptr     <= ptr_inc(ptr);
              end else begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              sr      <= {1'b0, sr[DATA_WIDTH-1:1]};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cw_trace_reader.sv
// Directed bench for cw_trace_reader with an 8-bit x 4-word trace RAM.
module tb_cw_trace_reader;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DP = 4;

  logic          jtck = 1'b0;
  logic          jrstn = 1'b0;
  logic          jscan_sel = 1'b0;
  logic          jshift = 1'b0;
  logic          jupdate = 1'b0;
  logic          cap_done = 1'b0;
  logic [AW-1:0] trig_ptr = '0;
  logic          jtdo, rd_ce, busy, done;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] ram [16];

  int            n_vec = 0;
  int            n_err = 0;
  int            rce_cnt = 0;
  logic [AW-1:0] addr_q[$];

  typedef struct {
    logic [AW-1:0] tp;
    int            stall_at;
    logic [7:0]    exp_w [4];
    logic [AW-1:0] exp_a [4];
  } scen_t;
  scen_t tbl [4];

  cw_trace_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP)) dut (
    .jtck(jtck), .jrstn(jrstn), .jscan_sel(jscan_sel), .jshift(jshift),
    .jupdate(jupdate), .jtdo(jtdo), .cap_done(cap_done), .trig_ptr(trig_ptr),
    .rd_ce(rd_ce), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done)
  );

  always #5 jtck = ~jtck;

  // synchronous-read RAM; data holds until the next read
  always @(posedge jtck) if (rd_ce) rd_data <= ram[rd_addr];

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chkv(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // one JTAG cycle: drive at negedge, sample 1ns later
  task automatic cyc(input logic up, input logic sh, input logic sel);
    @(negedge jtck);
    jupdate = up; jshift = sh; jscan_sel = sel;
    #1;
    if (rd_ce) begin
      rce_cnt++;
      addr_q.push_back(rd_addr);
    end
  endtask

  task automatic start(input logic [AW-1:0] tp, input logic sh);
    addr_q.delete();
    rce_cnt = 0;
    trig_ptr = tp;
    cyc(1'b1, sh, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    chk1("fetch_busy", busy, 1'b1);
    chk1("fetch_rd_ce", rd_ce, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    chk1("load_rd_ce", rd_ce, 1'b0);
  endtask

  task automatic shift_words(input int stall_at, output logic [3:0][7:0] w);
    w = '0;
    for (int k = 0; k < 32; k++) begin
      if (k == stall_at) repeat (5) cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 1'b1);
      w[k / 8][k % 8] = jtdo;
    end
  endtask

  task automatic check_run(input logic [7:0] ew [4], input logic [AW-1:0] ea [4]);
    logic [3:0][7:0] w;
    logic [7:0] a;
    shift_words(-1, w);
    cyc(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chkv($sformatf("word%0d", i), w[i], ew[i]);
      a = (i < addr_q.size()) ? 8'(addr_q[i]) : 8'hFF;
      chkv($sformatf("addr%0d", i), a, 8'(ea[i]));
    end
    chk1("end_done", done, 1'b1);
  endtask

  initial begin
    logic [3:0][7:0] w;
    logic [7:0] a;
    logic [7:0] ew [4];
    logic [AW-1:0] ea [4];

    for (int i = 0; i < 16; i++) ram[i] = 8'h00;
    ram[0] = 8'hA1; ram[1] = 8'hB2; ram[2] = 8'hC3; ram[3] = 8'hD4;

    tbl[0].tp = 4'd1; tbl[0].stall_at = -1;
    tbl[0].exp_w = '{8'hC3, 8'hD4, 8'hA1, 8'hB2}; tbl[0].exp_a = '{4'd2, 4'd3, 4'd0, 4'd1};
    tbl[1].tp = 4'd1; tbl[1].stall_at = 6;
    tbl[1].exp_w = '{8'hC3, 8'hD4, 8'hA1, 8'hB2}; tbl[1].exp_a = '{4'd2, 4'd3, 4'd0, 4'd1};
    tbl[2].tp = 4'd3; tbl[2].stall_at = -1;
    tbl[2].exp_w = '{8'hA1, 8'hB2, 8'hC3, 8'hD4}; tbl[2].exp_a = '{4'd0, 4'd1, 4'd2, 4'd3};
    tbl[3].tp = 4'd2; tbl[3].stall_at = 13;
    tbl[3].exp_w = '{8'hD4, 8'hA1, 8'hB2, 8'hC3}; tbl[3].exp_a = '{4'd3, 4'd0, 4'd1, 4'd2};

    // reset state
    #1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_rd_ce", rd_ce, 1'b0);
    chk1("rst_jtdo", jtdo, 1'b0);
    @(negedge jtck);
    jrstn = 1'b1;
    cap_done = 1'b1;

    // table-driven full readouts
    for (int s = 0; s < 4; s++) begin
      start(tbl[s].tp, 1'b0);
      shift_words(tbl[s].stall_at, w);
      cyc(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
        chkv($sformatf("s%0d_word%0d", s, i), w[i], tbl[s].exp_w[i]);
        a = (i < addr_q.size()) ? 8'(addr_q[i]) : 8'hFF;
        chkv($sformatf("s%0d_addr%0d", s, i), a, 8'(tbl[s].exp_a[i]));
      end
      chkv($sformatf("s%0d_rd_ce_cnt", s), 8'(rce_cnt), 8'd4);
      chk1($sformatf("s%0d_done", s), done, 1'b1);
      chk1($sformatf("s%0d_busy", s), busy, 1'b0);
      chk1($sformatf("s%0d_jtdo", s), jtdo, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
      chk1($sformatf("s%0d_abort_done", s), done, 1'b0);
    end

    // jupdate without cap_done is ignored
    cap_done = 1'b0;
    rce_cnt = 0;
    cyc(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      chk1($sformatf("nocap_busy%0d", i), busy, 1'b0);
      chk1($sformatf("nocap_rd_ce%0d", i), rd_ce, 1'b0);
    end
    chkv("nocap_rd_ce_cnt", 8'(rce_cnt), 8'd0);
    cap_done = 1'b1;

    // drop jscan_sel after 10 shifts
    start(4'd1, 1'b0);
    repeat (10) cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    chk1("abort_jtdo_gated", jtdo, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    chk1("abort_jtdo", jtdo, 1'b0);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_rd_ce", rd_ce, 1'b0);

    // restart mid-SHIFT, jupdate together with jshift
    start(4'd1, 1'b0);
    repeat (12) cyc(1'b0, 1'b1, 1'b1);
    start(4'd3, 1'b1);
    a = (addr_q.size() > 0) ? 8'(addr_q[0]) : 8'hFF;
    chkv("restart_addr", a, 8'd0);
    ew = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    ea = '{4'd0, 4'd1, 4'd2, 4'd3};
    check_run(ew, ea);
    cyc(1'b0, 1'b0, 1'b0);

    // asynchronous reset mid-SHIFT
    start(4'd2, 1'b0);
    repeat (8) cyc(1'b0, 1'b1, 1'b1);
    chk1("pre_rst_jtdo", jtdo, 1'b1);
    #2;
    jrstn = 1'b0;
    #1;
    chk1("arst_jtdo", jtdo, 1'b0);
    chk1("arst_rd_ce", rd_ce, 1'b0);
    chk1("arst_busy", busy, 1'b0);
    chk1("arst_done", done, 1'b0);
    chkv("arst_rd_addr", 8'(rd_addr), 8'd0);
    @(negedge jtck);
    jrstn = 1'b1;
    cyc(1'b0, 1'b1, 1'b1);
    chk1("post_rst_jtdo", jtdo, 1'b0);
    chk1("post_rst_busy", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
